// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: widths and FSM encoding shared with the upstream divider
package bin2bcd_seq_pkg;
    localparam int X_W = 24;
    localparam int BCD_DIGITS = 8;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    typedef logic [0:0] state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
    localparam int CNT_W = $clog2(X_W + 1);
endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/ready handshake and result bus of the converter
interface bin2bcd_seq_if
    import bin2bcd_seq_pkg::*;
#(
    parameter int x = X_W,
    parameter int DIGITS = BCD_DIGITS
);
    logic start;
    logic [x-1:0] bin;
    logic busy;
    logic ready;
    logic [4*DIGITS-1:0] bcd;
    modport master(output start, bin, input busy, ready, bcd);
    modport slave(input start, bin, output busy, ready, bcd);
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3_digit: double-dabble correction of one BCD digit
module bcd_add3_digit (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);
    assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to packed BCD converter
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int x = X_W,
    parameter int DIGITS = BCD_DIGITS
) (
    input logic clk,
    input logic reset,
    bin2bcd_seq_if.slave bus
);
    localparam int CW = cnt_w(x);
    localparam int BW = 4 * DIGITS;
    state_t state;
    logic [CW-1:0] cnt;
    logic [x-1:0] bin_sr;
    logic [BW-1:0] work;
    logic [BW-1:0] adj;
    logic [BW+x-1:0] sh;
    logic [BW-1:0] bcd;
    logic busy;
    logic ready;
    logic last;
    genvar d;
    for (d = 0; d < DIGITS; d++) begin : g_dig
        bcd_add3_digit u_add3 (.digit(work[4*d +: 4]), .fixed(adj[4*d +: 4]));
    end
    // corrected digits and binary register shift as one wide register
    assign sh = {adj, bin_sr} << 1;
    assign last = (cnt == CW'(1));
    assign bus.busy = busy;
    assign bus.ready = ready;
    assign bus.bcd = bcd;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            busy <= 1'b0;
            ready <= 1'b0;
        end else if (state == IDLE) begin
            ready <= 1'b0;
            if (bus.start) begin
                state <= SHIFT;
                cnt <= CW'(x);
                busy <= 1'b1;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (last) begin
                state <= IDLE;
                ready <= 1'b1;
                busy <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            bin_sr <= '0;
            work <= '0;
            bcd <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                bin_sr <= bus.bin;
                work <= '0;
            end
        end else begin
            work <= sh[BW+x-1:x];
            bin_sr <= sh[x-1:0];
            if (last) bcd <= sh[BW+x-1:x];
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: vector table, corner sequences and random check against a decimal model
module tb_bin2bcd_seq;
    localparam int X = 24;
    localparam int DG = 8;
    localparam int SX = 8;
    localparam int SD = 3;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bin2bcd_seq_if #(.x(X), .DIGITS(DG)) u_if ();
    bin2bcd_seq_if #(.x(SX), .DIGITS(SD)) s_if ();
    bin2bcd_seq #(.x(X), .DIGITS(DG)) dut (.clk(clk), .reset(reset), .bus(u_if));
    bin2bcd_seq #(.x(SX), .DIGITS(SD)) dut_s (.clk(clk), .reset(reset), .bus(s_if));
    always #5 clk = ~clk;
    typedef struct {
        logic [23:0] bin;
        logic [31:0] bcd;
    } vec_t;
    vec_t vecs[8];
    function automatic logic [31:0] model(input longint v);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic convert(input logic [23:0] v, output logic [31:0] res, output int lat, output int bsy);
        u_if.start = 1'b1;
        u_if.bin = v;
        tick();
        u_if.start = 1'b0;
        lat = 0;
        bsy = 0;
        while (!u_if.ready && lat < 100) begin
            bsy += int'(u_if.busy);
            tick();
            lat++;
        end
        res = u_if.bcd;
        tick();
        chk("ready_width", 64'(u_if.ready), 64'd0);
    endtask
    initial begin
        logic [31:0] res;
        int lat, bsy, pulses, prev, w;
        logic [23:0] v;
        if (!(64'd10 ** DG > (64'd1 << X) - 1) || !(64'd10 ** SD > (64'd1 << SX) - 1))
            $fatal(1, "FAIL digits_constraint DIGITS too small for width");
        vecs[0] = '{24'd0, 32'h00000000};
        vecs[1] = '{24'd16777215, 32'h16777215};
        vecs[2] = '{24'd999, 32'h00000999};
        vecs[3] = '{24'd10, 32'h00000010};
        vecs[4] = '{24'd9, 32'h00000009};
        vecs[5] = '{24'd5, 32'h00000005};
        vecs[6] = '{24'd9999999, 32'h09999999};
        vecs[7] = '{24'd10000000, 32'h10000000};
        u_if.start = 1'b1;
        u_if.bin = 24'd77;
        s_if.start = 1'b0;
        s_if.bin = '0;
        tick();
        tick();
        chk("reset_busy", 64'(u_if.busy), 64'd0);
        chk("reset_ready", 64'(u_if.ready), 64'd0);
        chk("reset_bcd", 64'(u_if.bcd), 64'd0);
        u_if.start = 1'b0;
        reset = 1'b1;
        tick();
        chk("idle_busy", 64'(u_if.busy), 64'd0);
        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].bin, res, lat, bsy);
            chk($sformatf("vec%0d_bcd", i), 64'(res), 64'(vecs[i].bcd));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd24);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bsy), 64'd24);
        end
        u_if.start = 1'b1;
        u_if.bin = 24'd123456;
        tick();
        pulses = 0;
        for (int c = 1; c <= 60; c++) begin
            u_if.start = (c == 5 || c == 10);
            u_if.bin = 24'd42;
            tick();
            pulses += int'(u_if.ready);
        end
        chk("ignore_start_pulses", 64'(pulses), 64'd1);
        chk("ignore_start_bcd", 64'(u_if.bcd), 64'h00123456);
        u_if.start = 1'b1;
        u_if.bin = 24'd500000;
        tick();
        u_if.start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_busy", 64'(u_if.busy), 64'd0);
        chk("abort_bcd", 64'(u_if.bcd), 64'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            pulses += int'(u_if.ready);
        end
        chk("abort_no_ready", 64'(pulses), 64'd0);
        convert(24'd7, res, lat, bsy);
        chk("after_abort_bcd", 64'(res), 64'h00000007);
        u_if.start = 1'b1;
        u_if.bin = 24'd1;
        tick();
        prev = cyc;
        for (int i = 1; i <= 3; i++) begin
            w = 0;
            while (!u_if.ready && w < 100) begin
                tick();
                w++;
            end
            chk($sformatf("b2b%0d_bcd", i), 64'(u_if.bcd), 64'(model(i)));
            chk($sformatf("b2b%0d_gap", i), 64'(cyc - prev), (i == 1) ? 64'd24 : 64'd25);
            prev = cyc;
            u_if.bin = 24'(i + 1);
            tick();
            chk($sformatf("b2b%0d_ready_width", i), 64'(u_if.ready), 64'd0);
        end
        u_if.start = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        for (int i = 0; i < 1000; i++) begin
            v = 24'($urandom);
            v = v >> $urandom_range(0, 23);
            convert(v, res, lat, bsy);
            chk($sformatf("rand%0d_%0d", i, v), 64'(res), 64'(model(longint'(v))));
        end
        s_if.start = 1'b1;
        s_if.bin = 8'd255;
        tick();
        s_if.start = 1'b0;
        w = 0;
        while (!s_if.ready && w < 100) begin
            tick();
            w++;
        end
        chk("small_255_bcd", 64'(s_if.bcd), 64'h255);
        chk("small_255_latency", 64'(w), 64'd8);
        for (int i = 0; i < 20; i++) begin
            v = 24'($urandom_range(0, 255));
            s_if.start = 1'b1;
            s_if.bin = v[7:0];
            tick();
            s_if.start = 1'b0;
            w = 0;
            while (!s_if.ready && w < 100) begin
                tick();
                w++;
            end
            chk($sformatf("small_rand_%0d", v), 64'(s_if.bcd), 64'(model(longint'(v)) & 32'hfff));
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
